// File: rtl/pcm_pkg.sv
// Shared sizing for the PCM packer and its FIFO wrapper.
// Slot helper maps a fill index to the MSB of its sample field.
package pcm_pkg;

  localparam int PCM_SAMPLE_W         = 12;
  localparam int PCM_SAMPLES_PER_WORD = 10;
  localparam int PCM_WORD_W           = PCM_SAMPLE_W * PCM_SAMPLES_PER_WORD;

  // First sample sits in the top field of the word.
  function automatic int fill_slot(
    input int idx,
    input int sw = PCM_SAMPLE_W,
    input int n  = PCM_SAMPLES_PER_WORD
  );
    return sw * n - 1 - sw * idx;
  endfunction

endpackage

// File: rtl/pcm_strobe_edge.sv
// Rising-edge detect of the sample strobe with aligned sample data.
// PCM_PACK_SYNC_EN adds a 2-flop synchronizer for a foreign-domain divider.
module pcm_strobe_edge #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_clk,
  input  logic [W-1:0] pcm_in,
  output logic         strobe,
  output logic [W-1:0] sample
);

`ifdef PCM_PACK_SYNC_EN
  logic         s1;
  logic         s2;
  logic         sclk_d;
  logic [W-1:0] p1;
  logic [W-1:0] p2;

  // Data rides the same two stages so it lines up with the delayed edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      sclk_d <= 1'b0;
      p1     <= '0;
      p2     <= '0;
    end else begin
      s1     <= sample_clk;
      s2     <= s1;
      sclk_d <= s2;
      p1     <= pcm_in;
      p2     <= p1;
    end
  end

  assign strobe = s2 & ~sclk_d;
  assign sample = p2;
`else
  logic sclk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d <= 1'b0;
    end else begin
      sclk_d <= sample_clk;
    end
  end

  assign strobe = sample_clk & ~sclk_d;
  assign sample = pcm_in;
`endif

endmodule

// File: rtl/pcm_word_packer.sv
// Packs SAMPLES_PER_WORD PCM samples per word into a FIFO, double-buffered.
// Define PCM_PACK_SYNC_EN to synchronize sample_clk from another domain.
module pcm_word_packer
  import pcm_pkg::*;
#(
  parameter  int SAMPLE_W         = PCM_SAMPLE_W,
  parameter  int SAMPLES_PER_WORD = PCM_SAMPLES_PER_WORD,
  localparam int WORD_W           = SAMPLE_W * SAMPLES_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_clk,
  input  logic              enable,
  input  logic [SAMPLE_W-1:0] pcm_in,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [WORD_W-1:0] fifo_din,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int IDX_W = $clog2(SAMPLES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

  logic                strobe;
  logic [SAMPLE_W-1:0] sample;
  logic [WORD_W-1:0]   fill_reg;
  logic [WORD_W-1:0]   fill_nxt;
  logic [WORD_W-1:0]   out_reg;
  logic [IDX_W-1:0]    fill_idx;
  logic                pending;
  logic                take;
  logic                complete;
  logic                drop;

  pcm_strobe_edge #(
    .W (SAMPLE_W)
  ) u_edge (
    .clk        (clk),
    .reset      (reset),
    .sample_clk (sample_clk),
    .pcm_in     (pcm_in),
    .strobe     (strobe),
    .sample     (sample)
  );

  // Word as it will look once the current sample is merged in.
  always_comb begin
    fill_nxt = fill_reg;
    fill_nxt[fill_slot(int'(fill_idx), SAMPLE_W, SAMPLES_PER_WORD) -: SAMPLE_W] = sample;
  end

  assign take     = enable & strobe;
  assign complete = take & (fill_idx == LAST_IDX);
  assign drop     = complete & pending;
  assign fifo_din = out_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_reg <= '0;
      fill_idx <= '0;
      out_reg  <= '0;
      pending  <= 1'b0;
      fifo_wr  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      fifo_wr <= pending & ~fifo_full;

      if (complete & ~pending) begin
        pending <= 1'b1;
        out_reg <= fill_nxt;
      end else if (pending & ~fifo_full) begin
        pending <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      if (!enable) begin
        fill_reg <= '0;
        fill_idx <= '0;
      end else if (take) begin
        fill_reg <= fill_nxt;
        fill_idx <= complete ? '0 : fill_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pcm_word_packer.sv
// Directed bench for pcm_word_packer: packing, stall, drop, enable, reset.
// Write latency expectations follow PCM_PACK_SYNC_EN.
module tb_pcm_word_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sample_clk = 1'b0;
  logic         enable = 1'b0;
  logic [11:0]  pcm_in = '0;
  logic         fifo_full = 1'b0;
  logic         clr_ovr = 1'b0;
  logic         fifo_wr;
  logic [119:0] fifo_din;
  logic         overrun;

`ifdef PCM_PACK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  int           n_run = 0;
  int           n_fail = 0;
  int           wr_count = 0;
  int           c0;
  logic         prev_wr = 1'b0;
  logic [119:0] last_din = '0;

  pcm_word_packer dut (
    .clk        (clk),
    .reset      (reset),
    .sample_clk (sample_clk),
    .enable     (enable),
    .pcm_in     (pcm_in),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [119:0] got,
                     input logic [119:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [119:0] mk(input int base);
    logic [119:0] w = '0;
    for (int i = 0; i < 10; i++) w = {w[107:0], 12'(base + i)};
    return w;
  endfunction

  task automatic send(input int v);
    @(negedge clk);
    sample_clk = 1'b1;
    pcm_in     = 12'(v);
    @(negedge clk);
    sample_clk = 1'b0;
  endtask

  task automatic send_n(input int base, input int n);
    for (int i = 0; i < n; i++) send(base + i);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (fifo_wr) begin
      chk("wr_width", 120'(prev_wr), 120'(0));
      wr_count++;
      last_din = fifo_din;
    end
    prev_wr = fifo_wr;
  end

  initial begin
    settle(3);
    chk("rst_wr", 120'(fifo_wr), 120'(0));
    chk("rst_din", fifo_din, 120'(0));
    chk("rst_ovr", 120'(overrun), 120'(0));
    reset  = 1'b0;
    enable = 1'b1;
    settle(1);

    // 1: single word, latency and data
    send_n(1, 10);
    chk("t1_early", 120'(fifo_wr), 120'(0));
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      chk("t1_early", 120'(fifo_wr), 120'(0));
    end
    @(negedge clk);
    chk("t1_wr", 120'(fifo_wr), 120'(1));
    chk("t1_din", fifo_din, mk(1));
    @(negedge clk);
    chk("t1_pulse", 120'(fifo_wr), 120'(0));

    // 2: two words back to back
    settle(2);
    c0 = wr_count;
    send_n(32, 20);
    settle(6);
    chk("t2_count", 120'(wr_count - c0), 120'(2));
    chk("t2_din", last_din, mk(42));
    chk("t2_ovr", 120'(overrun), 120'(0));

    // 3: full stall, drop, release
    fifo_full = 1'b1;
    c0 = wr_count;
    send_n(12'h300, 19);
    settle(4);
    chk("t3_ovr19", 120'(overrun), 120'(0));
    send(12'h313);
    settle(4);
    chk("t3_nowr", 120'(wr_count - c0), 120'(0));
    chk("t3_din", fifo_din, mk(12'h300));
    chk("t3_ovr", 120'(overrun), 120'(1));
    fifo_full = 1'b0;
    settle(4);
    chk("t3_count", 120'(wr_count - c0), 120'(1));
    chk("t3_wdin", last_din, mk(12'h300));
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    settle(1);
    chk("t3_clr", 120'(overrun), 120'(0));

    // 4: enable drop discards partial word
    send_n(12'h400, 5);
    settle(4);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    c0 = wr_count;
    send_n(12'h100, 10);
    settle(6);
    chk("t4_count", 120'(wr_count - c0), 120'(1));
    chk("t4_din", last_din, mk(12'h100));

    // 5: async reset while pending, overrun set and a partial word
    fifo_full = 1'b1;
    send_n(12'h500, 25);
    settle(4);
    chk("t5_pre_ovr", 120'(overrun), 120'(1));
    chk("t5_pre_din", fifo_din, mk(12'h500));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_wr", 120'(fifo_wr), 120'(0));
    chk("t5_din", fifo_din, 120'(0));
    chk("t5_ovr", 120'(overrun), 120'(0));
    @(negedge clk);
    reset     = 1'b0;
    fifo_full = 1'b0;
    c0 = wr_count;
    settle(10);
    chk("t5_nowr", 120'(wr_count - c0), 120'(0));
    send_n(12'h600, 9);
    settle(6);
    chk("t5_part", 120'(wr_count - c0), 120'(0));
    send(12'h609);
    settle(6);
    chk("t5_count", 120'(wr_count - c0), 120'(1));
    chk("t5_wdin", last_din, mk(12'h600));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
